instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/otter_fetch_pkg.sv | 21 ++
 rtl/fetch_timeout_counter.sv | 32 +++
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/otter_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset instruction and the WAIT/DRAIN timeout counter width.
package otter_fetch_pkg;

    localparam logic [31:0] RESET_NOP_DEFAULT = 32'h00000013;
    localparam int unsigned TIMEOUT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_HOLD,
        ST_ERR
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on a memory response; flags expiry on the
// MEM_TIMEOUT-th consecutive enabled cycle.
module fetch_timeout_counter
    import otter_fetch_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // count is 0 in the first waiting cycle, so LIMIT is reached on cycle MEM_TIMEOUT
    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM: requests IF_PC, holds the fetched
// word for decode, handles flush/redirect, misalignment and bus timeouts.
module instr_fetch_unit
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_NOP   = RESET_NOP_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IF_PC,
    input  logic        IF_FLUSH,
    input  logic        IF_MEM_GNT,
    input  logic        IF_MEM_RVALID,
    input  logic [31:0] IF_MEM_RDATA,
    input  logic        IF_INSTR_READY,
    output logic        IF_MEM_REQ,
    output logic [31:0] IF_MEM_ADDR,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_INSTR_PC,
    output logic        IF_INSTR_VALID,
    output logic        IF_PC_WRITE,
    output logic [31:0] IF_NEXT_PC,
    output logic        IF_MISALIGN_ERR,
    output logic        IF_BUS_ERR
);

    fetch_state_t state, state_next;
    logic         misaligned;
    logic         capture;
    logic         set_misalign;
    logic         set_bus;
    logic         clear_err;
    logic         timer_clear;
    logic         timer_enable;
    logic         timer_expired;

    assign misaligned = is_misaligned(IF_PC);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        IF_MEM_REQ     = 1'b0;
        IF_INSTR_VALID = 1'b0;
        IF_PC_WRITE    = 1'b0;
        capture        = 1'b0;
        set_misalign   = 1'b0;
        set_bus        = 1'b0;
        clear_err      = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                // A misaligned PC never reaches the bus, so its GNT is meaningless
                IF_MEM_REQ = !misaligned;
                if (IF_FLUSH) begin
                    state_next = (IF_MEM_GNT && !misaligned) ? ST_DRAIN : ST_REQ;
                end else if (misaligned) begin
                    state_next   = ST_ERR;
                    set_misalign = 1'b1;
                end else if (IF_MEM_GNT) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (IF_MEM_RVALID) begin
                    if (IF_FLUSH) begin
                        state_next = ST_REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = ST_HOLD;
                    end
                end else if (IF_FLUSH) begin
                    state_next = ST_DRAIN;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                    set_bus    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (IF_MEM_RVALID) begin
                    state_next = ST_REQ;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                    set_bus    = 1'b1;
                end
            end
            ST_HOLD: begin
                IF_INSTR_VALID = 1'b1;
                if (IF_FLUSH) begin
                    state_next = ST_REQ;
                end else if (IF_INSTR_READY) begin
                    IF_PC_WRITE = 1'b1;
                    state_next  = ST_REQ;
                end
            end
            ST_ERR: begin
                if (IF_FLUSH) begin
                    clear_err  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Any state change restarts the budget, so DRAIN gets a fresh timeout window
    assign timer_clear  = (state_next != state);
    assign timer_enable = (state == ST_WAIT) || (state == ST_DRAIN);

    fetch_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IF_INSTR    <= RESET_NOP;
            IF_INSTR_PC <= '0;
        end else if (IF_FLUSH) begin
            IF_INSTR <= RESET_NOP;
        end else if (capture) begin
            IF_INSTR    <= IF_MEM_RDATA;
            IF_INSTR_PC <= IF_PC;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IF_MISALIGN_ERR <= 1'b0;
            IF_BUS_ERR      <= 1'b0;
        end else if (clear_err) begin
            IF_MISALIGN_ERR <= 1'b0;
            IF_BUS_ERR      <= 1'b0;
        end else begin
            if (set_misalign) IF_MISALIGN_ERR <= 1'b1;
            if (set_bus)      IF_BUS_ERR      <= 1'b1;
        end
    end

    assign IF_MEM_ADDR = IF_PC;
    assign IF_NEXT_PC  = IF_INSTR_PC + 32'd4;

endmodule
